// File: rtl/vga_pkg.sv
// Constants and types shared by the VRAM writer and the scan-out path for the
// 320x240, 4 bpp packed frame buffer.
package vga_pkg;

    localparam int H_ACTIVE       = 320;
    localparam int V_ACTIVE       = 240;
    localparam int WORDS_PER_LINE = 80;
    localparam int VRAM_WORDS     = 19200;
    localparam int PIX_PER_WORD   = 4;

    typedef logic [3:0]  pixel_t;
    typedef logic [15:0] vram_word_t;

    typedef enum logic {
        OP_PLOT = 1'b0,
        OP_FILL = 1'b1
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        FILL = 3'd4
    } writer_state_t;

endpackage

// File: rtl/vram_addr_calc.sv
// Maps a pixel coordinate to its packed VRAM word, nibble index and an
// in-frame flag. Purely combinational; scan-out uses the same mapping.
module vram_addr_calc
    import vga_pkg::*;
(
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    output logic [15:0] word_addr,
    output logic [1:0]  nibble,
    output logic        in_range
);

    logic [15:0] y_w;

    assign y_w = {7'd0, y};

    // y*80 as two shifts keeps this a pair of adders, no multiplier
    assign word_addr = (y_w << 6) + (y_w << 4) + {9'd0, x[8:2]};
    assign nibble    = x[1:0];
    assign in_range  = (x < 9'(H_ACTIVE)) && (y < 9'(V_ACTIVE));

endmodule

// File: rtl/vram_pixel_writer.sv
// Port-B write agent for the packed frame buffer: single-pixel plots via
// read-modify-write of one nibble, and full-frame fills as a write stream.
module vram_pixel_writer
    import vga_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [8:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [3:0]  cmd_color,
    output logic [15:0] vram_addr,
    output logic        vram_re,
    input  logic [15:0] vram_rdata,
    output logic        vram_we,
    output logic [15:0] vram_wdata,
    output logic        done,
    output logic        err
);

    writer_state_t state, state_nxt;

    logic [15:0] calc_addr;
    logic [1:0]  calc_nib;
    logic        calc_in_range;

    logic [1:0]  nib_q;
    pixel_t      color_q;
    logic        accept;

    vram_word_t  addr_nxt, wdata_nxt;
    logic        re_nxt, we_nxt, done_nxt, err_nxt, ready_nxt;

    vram_addr_calc u_addr_calc (
        .x         (cmd_x),
        .y         (cmd_y),
        .word_addr (calc_addr),
        .nibble    (calc_nib),
        .in_range  (calc_in_range)
    );

    // Nibble 0 is the leftmost pixel, held in the top four bits.
    function automatic vram_word_t put_nibble(input vram_word_t w,
                                              input logic [1:0] n,
                                              input pixel_t c);
        vram_word_t r;
        r = w;
        case (n)
            2'd0:    r[15:12] = c;
            2'd1:    r[11:8]  = c;
            2'd2:    r[7:4]   = c;
            default: r[3:0]   = c;
        endcase
        return r;
    endfunction

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        addr_nxt  = vram_addr;
        wdata_nxt = vram_wdata;
        re_nxt    = 1'b0;
        we_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op_t'(cmd_op) == OP_FILL) begin
                        state_nxt = FILL;
                        addr_nxt  = '0;
                        wdata_nxt = {4{cmd_color}};
                        we_nxt    = 1'b1;
                    end else if (calc_in_range) begin
                        state_nxt = RD;
                        addr_nxt  = calc_addr;
                        re_nxt    = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            RD:   state_nxt = WAIT;
            // rdata for the word addressed in RD is valid in this cycle
            WAIT: begin
                state_nxt = WR;
                wdata_nxt = put_nibble(vram_rdata, nib_q, color_q);
                we_nxt    = 1'b1;
            end
            WR: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            FILL: begin
                if (vram_addr == 16'(VRAM_WORDS - 1)) begin
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt  = vram_addr + 16'd1;
                    we_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            vram_addr  <= '0;
            vram_re    <= 1'b0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_ready  <= ready_nxt;
            vram_addr  <= addr_nxt;
            vram_re    <= re_nxt;
            vram_we    <= we_nxt;
            vram_wdata <= wdata_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    // Plot fields are only consumed after accept, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            nib_q   <= calc_nib;
            color_q <= cmd_color;
        end
    end

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench: a pixel-level frame model predicts every VRAM word the
// writer should produce, and a behavioural RAM answers port-B reads.
module tb_vram_pixel_writer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [8:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [3:0]  cmd_color;
    logic [15:0] vram_addr;
    logic        vram_re;
    logic [15:0] vram_rdata;
    logic        vram_we;
    logic [15:0] vram_wdata;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] mem [0:19199];
    logic        pre_we = 1'b0;
    int          pre_addr = 0;
    logic [15:0] pre_data = '0;
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          last_re_cyc = -1;

    logic [3:0]  pix [0:239][0:319];

    vram_pixel_writer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_color  (cmd_color),
        .vram_addr  (vram_addr),
        .vram_re    (vram_re),
        .vram_rdata (vram_rdata),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (vram_we && vram_addr < 16'd19200)
            mem[vram_addr] <= vram_wdata;
        if (vram_re && vram_addr < 16'd19200)
            vram_rdata <= mem[vram_addr];
        if (vram_we) last_we_cyc <= cyc;
        if (vram_re) last_re_cyc <= cyc;
    end

    function automatic logic [15:0] model_word(input int wa);
        int r, c;
        r = wa / 80;
        c = (wa % 80) * 4;
        return {pix[r][c], pix[r][c+1], pix[r][c+2], pix[r][c+3]};
    endfunction

    task automatic set_model_word(input int wa, input logic [15:0] d);
        int r, c;
        r = wa / 80;
        c = (wa % 80) * 4;
        pix[r][c]   = d[15:12];
        pix[r][c+1] = d[11:8];
        pix[r][c+2] = d[7:4];
        pix[r][c+3] = d[3:0];
    endtask

    task automatic preload(input int wa, input logic [15:0] d);
        pre_addr = wa;
        pre_data = d;
        pre_we   = 1'b1;
        set_model_word(wa, d);
        @(posedge clock); #1;
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_color = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        n_cmp++;
        if ({cmd_ready, vram_re, vram_we, done, err} !== 5'b10000 ||
            vram_addr !== 16'd0 || vram_wdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: ready/re/we/done/err=%b addr=%0d wdata=%h, required 10000 addr=0 wdata=0000",
                     {cmd_ready, vram_re, vram_we, done, err}, vram_addr, vram_wdata);
        end
    endtask

    task automatic test_plot(input int x, input int y, input logic [3:0] c);
        int wa;
        logic [15:0] exp_w;
        bit inr;
        inr = (x < 320) && (y < 240);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = 9'(x);
        cmd_y     = 9'(y);
        cmd_color = c;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_x     = 9'($urandom);
        cmd_y     = 9'($urandom);
        cmd_color = 4'($urandom);
        if (inr) begin
            wa = y * 80 + x / 4;
            pix[y][x] = c;
            exp_w = model_word(wa);
            cmd_valid = 1'($urandom);
            cmd_op    = 1'($urandom);
            n_cmp++;
            if (!(vram_re === 1'b1 && vram_addr === 16'(wa) && cmd_ready === 1'b0 &&
                  vram_we === 1'b0 && err === 1'b0)) begin
                n_fail++;
                $display("FAIL plot_rd (%0d,%0d): re=%b addr=%0d ready=%b we=%b err=%b, required re=1 addr=%0d ready=0 we=0 err=0",
                         x, y, vram_re, vram_addr, cmd_ready, vram_we, err, wa);
            end
            @(posedge clock); #1;
            cmd_valid = 1'($urandom);
            n_cmp++;
            if (!(vram_re === 1'b0 && vram_we === 1'b0 && cmd_ready === 1'b0 && done === 1'b0)) begin
                n_fail++;
                $display("FAIL plot_wait (%0d,%0d): re=%b we=%b ready=%b done=%b, required 0 0 0 0",
                         x, y, vram_re, vram_we, cmd_ready, done);
            end
            @(posedge clock); #1;
            cmd_valid = 1'b0;
            cmd_op    = 1'b0;
            n_cmp++;
            if (!(vram_we === 1'b1 && vram_wdata === exp_w && vram_addr === 16'(wa) &&
                  vram_re === 1'b0 && cmd_ready === 1'b0)) begin
                n_fail++;
                $display("FAIL plot_wr (%0d,%0d): we=%b wdata=%h addr=%0d re=%b ready=%b, required we=1 wdata=%h addr=%0d re=0 ready=0",
                         x, y, vram_we, vram_wdata, vram_addr, vram_re, cmd_ready, exp_w, wa);
            end
            @(posedge clock); #1;
            n_cmp++;
            if (!(vram_we === 1'b0 && done === 1'b1 && cmd_ready === 1'b1 && err === 1'b0)) begin
                n_fail++;
                $display("FAIL plot_done (%0d,%0d): we=%b done=%b ready=%b err=%b, required we=0 done=1 ready=1 err=0",
                         x, y, vram_we, done, cmd_ready, err);
            end
        end else begin
            n_cmp++;
            if (!(err === 1'b1 && cmd_ready === 1'b1 && vram_re === 1'b0 &&
                  vram_we === 1'b0 && done === 1'b0)) begin
                n_fail++;
                $display("FAIL oob_err (%0d,%0d): err=%b ready=%b re=%b we=%b done=%b, required err=1 ready=1 re=0 we=0 done=0",
                         x, y, err, cmd_ready, vram_re, vram_we, done);
            end
            @(posedge clock); #1;
            n_cmp++;
            if (!(err === 1'b0 && cmd_ready === 1'b1 && vram_re === 1'b0 &&
                  vram_we === 1'b0 && done === 1'b0)) begin
                n_fail++;
                $display("FAIL oob_after (%0d,%0d): err=%b ready=%b re=%b we=%b done=%b, required err=0 ready=1 re=0 we=0 done=0",
                         x, y, err, cmd_ready, vram_re, vram_we, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_we;
        preload(81, 16'h0000);
        test_plot(6, 1, 4'hC);
        first_we = last_we_cyc;
        test_plot(7, 1, 4'h9);
        n_cmp++;
        if (!(last_re_cyc > first_we) || mem[81] !== 16'h00C9) begin
            n_fail++;
            $display("FAIL back_to_back: second re cycle %0d vs first we cycle %0d, word81=%h, required re after we and word81=00C9",
                     last_re_cyc, first_we, mem[81]);
        end
    endtask

    task automatic test_fill(input logic [3:0] c);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_color = c;
        cmd_x     = 9'($urandom);
        cmd_y     = 9'($urandom);
        @(posedge clock); #1;
        for (int i = 0; i < 19200; i++) begin
            if (!(vram_we === 1'b1 && vram_addr === 16'(i) && vram_wdata === {4{c}} &&
                  cmd_ready === 1'b0 && done === 1'b0 && vram_re === 1'b0 && err === 1'b0)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            cmd_valid = (i == 19199) ? 1'b0 : 1'($urandom);
            cmd_op    = 1'($urandom);
            cmd_color = 4'($urandom);
            @(posedge clock); #1;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fill_stream: %0d bad write cycles (first at %0d, addr=%0d wdata=%h), required 0",
                     bad, first_bad, vram_addr, vram_wdata);
        end
        n_cmp++;
        if (!(vram_we === 1'b0 && vram_addr === 16'd0 && done === 1'b1 && cmd_ready === 1'b1)) begin
            n_fail++;
            $display("FAIL fill_done: we=%b addr=%0d done=%b ready=%b, required we=0 addr=0 done=1 ready=1",
                     vram_we, vram_addr, done, cmd_ready);
        end
        for (int r = 0; r < 240; r++)
            for (int x = 0; x < 320; x++)
                pix[r][x] = c;
        @(posedge clock); #1;
        n_cmp++;
        if (!(done === 1'b0 && vram_we === 1'b0 && vram_re === 1'b0)) begin
            n_fail++;
            $display("FAIL fill_idle: done=%b we=%b re=%b, required 0 0 0", done, vram_we, vram_re);
        end
    endtask

    task automatic test_random_plots(input int n);
        for (int k = 0; k < n; k++)
            test_plot(int'($urandom_range(0, 335)), int'($urandom_range(0, 250)), 4'($urandom));
    endtask

    task automatic test_frame_compare();
        int bad;
        bad = 0;
        for (int k = 0; k < 19200; k++)
            if (mem[k] !== model_word(k)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frame_compare: %0d words differ from model, required 0", bad);
        end
    endtask

    task automatic test_fill_reset();
        bit hit;
        hit = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_color = 4'hE;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (vram_addr === 16'd100 && vram_we === 1'b1) hit = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL fill_reach_100: addr=%0d we=%b, required addr 100 with we=1 within budget", vram_addr, vram_we);
        end
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k <= 100; k++) set_model_word(k, 16'hEEEE);
        n_cmp++;
        if (!(vram_we === 1'b0 && vram_addr === 16'd0 && cmd_ready === 1'b1 &&
              done === 1'b0 && vram_re === 1'b0 && err === 1'b0)) begin
            n_fail++;
            $display("FAIL fill_reset: we=%b addr=%0d ready=%b done=%b re=%b err=%b, required we=0 addr=0 ready=1 done=0 re=0 err=0",
                     vram_we, vram_addr, cmd_ready, done, vram_re, err);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (!(vram_we === 1'b0 && done === 1'b0 && cmd_ready === 1'b1)) begin
            n_fail++;
            $display("FAIL fill_reset_after: we=%b done=%b ready=%b, required we=0 done=0 ready=1",
                     vram_we, done, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        preload(0, 16'h1234);
        test_plot(0, 0, 4'hA);
        preload(19199, 16'hFFFF);
        test_plot(319, 239, 4'h5);
        test_back_to_back();
        test_plot(320, 0, 4'h1);
        test_plot(0, 240, 4'h2);
        test_fill(4'h3);
        test_random_plots(40);
        test_frame_compare();
        test_fill_reset();
        preload(1, 16'h3333);
        test_plot(4, 0, 4'h7);
        n_cmp++;
        if (mem[1] !== 16'h7333) begin
            n_fail++;
            $display("FAIL plot_after_reset: word1=%h, required 7333", mem[1]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
